// File: rtl/data_memory_param_pkg.sv
// Shared types and helpers for the parametrised data memory.
package data_memory_pkg;

  typedef enum logic {
    INIT  = 1'b0,
    READY = 1'b1
  } mem_state_e;

  localparam int MAX_READ_LATENCY = 4;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return r;
  endfunction

endpackage

// File: rtl/data_memory_param_if.sv
// Load/store port of the data memory.
// Requests are sampled on the rising edge only while ready=1; a read result is
// valid exactly in the cycle read_valid=1, and read_data holds between results.
interface data_memory_param_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32
);
  logic [ADDR_WIDTH-1:0]   address;
  logic [DATA_WIDTH-1:0]   write_data;
  logic [DATA_WIDTH/8-1:0] byte_enable;
  logic                    memory_read;
  logic                    memory_write;
  logic [DATA_WIDTH-1:0]   read_data;
  logic                    read_valid;
  logic                    addr_error;
  logic                    ready;

  modport master (
    output address, write_data, byte_enable, memory_read, memory_write,
    input  read_data, read_valid, addr_error, ready
  );

  modport slave (
    input  address, write_data, byte_enable, memory_read, memory_write,
    output read_data, read_valid, addr_error, ready
  );
endinterface

// File: rtl/data_memory_param_read_delay_pipe.sv
// Delays a {valid, data} pair by READ_LATENCY registers; each stage's data
// only loads alongside a valid token so the last stage holds its last result.
module read_delay_pipe #(
  parameter int READ_LATENCY = 1,
  parameter int DATA_WIDTH   = 32
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  valid_i,
  input  logic [DATA_WIDTH-1:0] data_i,
  output logic                  valid_o,
  output logic [DATA_WIDTH-1:0] data_o
);

  logic                  valid_q [READ_LATENCY];
  logic [DATA_WIDTH-1:0] data_q  [READ_LATENCY];

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int k = 0; k < READ_LATENCY; k++) begin
        valid_q[k] <= 1'b0;
        data_q[k]  <= '0;
      end
    end else begin
      valid_q[0] <= valid_i;
      if (valid_i) data_q[0] <= data_i;
      for (int k = 1; k < READ_LATENCY; k++) begin
        valid_q[k] <= valid_q[k-1];
        if (valid_q[k-1]) data_q[k] <= data_q[k-1];
      end
    end
  end

  assign valid_o = valid_q[READ_LATENCY-1];
  assign data_o  = data_q[READ_LATENCY-1];

endmodule

// File: rtl/data_memory_param.sv
// Parametrised word-organised data memory with byte enables, address checking,
// a post-reset zeroing sweep and a configurable read latency (1..4).
module data_memory_param
  import data_memory_pkg::*;
#(
  parameter int DATA_WIDTH   = 32,
  parameter int ADDR_WIDTH   = 32,
  parameter int DEPTH_LOG2   = 6,
  parameter int READ_LATENCY = 1
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  data_memory_param_if.slave   bus,
  output mem_state_e           state_o
);

  localparam int BYTES = DATA_WIDTH / 8;
  localparam int BL    = clog2(BYTES);
  localparam int WORDS = 1 << DEPTH_LOG2;
  localparam int HI    = DEPTH_LOG2 + BL;

  mem_state_e            state_q, state_d;
  logic [DEPTH_LOG2-1:0] sweep_q, sweep_d;
  logic                  addr_err_q, addr_err_d;
  logic [DATA_WIDTH-1:0] mem_q [WORDS];

  logic                  ready;
  logic                  misaligned, out_of_range, addr_bad;
  logic                  rd_acc, wr_acc;
  logic [DEPTH_LOG2-1:0] word_idx;
  logic [DATA_WIDTH-1:0] rd_word;
  logic                  pipe_valid;
  logic [DATA_WIDTH-1:0] pipe_data;

  // Upper bits are checked rather than truncated so indices never wrap.
  assign misaligned   = |bus.address[BL-1:0];
  assign out_of_range = |bus.address[ADDR_WIDTH-1:HI];
  assign addr_bad     = misaligned | out_of_range;
  assign word_idx     = bus.address[HI-1:BL];

  assign rd_acc     = ready & bus.memory_read;
  assign wr_acc     = ready & bus.memory_write;
  assign addr_err_d = (rd_acc | wr_acc) & addr_bad;
  assign rd_word    = addr_bad ? '0 : mem_q[word_idx];

  always_comb begin
    state_d = state_q;
    sweep_d = sweep_q;
    ready   = 1'b0;
    case (state_q)
      INIT: begin
        sweep_d = sweep_q + 1'b1;
        if (&sweep_q) state_d = READY;
      end
      READY:   ready = 1'b1;
      default: state_d = INIT;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= INIT;
      sweep_q    <= '0;
      addr_err_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      sweep_q    <= sweep_d;
      addr_err_q <= addr_err_d;
    end
  end

  // Array is not reset; the INIT sweep clears it one word per cycle.
  always_ff @(posedge clk_i) begin
    if (state_q == INIT) begin
      mem_q[sweep_q] <= '0;
    end else if (wr_acc && !addr_bad) begin
      for (int i = 0; i < BYTES; i++) begin
        if (bus.byte_enable[i]) mem_q[word_idx][8*i +: 8] <= bus.write_data[8*i +: 8];
      end
    end
  end

  read_delay_pipe #(
    .READ_LATENCY (READ_LATENCY),
    .DATA_WIDTH   (DATA_WIDTH)
  ) u_read_pipe (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .valid_i (rd_acc),
    .data_i  (rd_word),
    .valid_o (pipe_valid),
    .data_o  (pipe_data)
  );

  assign bus.read_valid = pipe_valid;
  assign bus.read_data  = pipe_data;
  assign bus.addr_error = addr_err_q;
  assign bus.ready      = ready;
  assign state_o        = state_q;

endmodule

// File: tb/tb_data_memory_param.sv
// Directed bench for data_memory_param: one instance at read latency 1 and
// one at read latency 3 share clock and reset.
module tb_data_memory_param;
  import data_memory_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  data_memory_param_if #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) if1 ();
  data_memory_param_if #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) if3 ();
  mem_state_e st1, st3;

  data_memory_param #(
    .DATA_WIDTH(32), .ADDR_WIDTH(32), .DEPTH_LOG2(6), .READ_LATENCY(1)
  ) dut1 (.clk_i(clk), .rst_i(rst), .bus(if1.slave), .state_o(st1));

  data_memory_param #(
    .DATA_WIDTH(32), .ADDR_WIDTH(32), .DEPTH_LOG2(6), .READ_LATENCY(3)
  ) dut3 (.clk_i(clk), .rst_i(rst), .bus(if3.slave), .state_o(st3));

  int vectors = 0;
  int miscompares = 0;
  logic [31:0] exp_q[$];

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%08h want 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_all();
    if1.address = '0; if1.write_data = '0; if1.byte_enable = '0;
    if1.memory_read = 1'b0; if1.memory_write = 1'b0;
    if3.address = '0; if3.write_data = '0; if3.byte_enable = '0;
    if3.memory_read = 1'b0; if3.memory_write = 1'b0;
  endtask

  task automatic wr(input int sel, input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
    if (sel == 1) begin
      if1.address = a; if1.write_data = d; if1.byte_enable = be; if1.memory_write = 1'b1;
    end else begin
      if3.address = a; if3.write_data = d; if3.byte_enable = be; if3.memory_write = 1'b1;
    end
    tick();
    idle_all();
  endtask

  task automatic rd1(input string tag, input logic [31:0] a, input logic [31:0] exp);
    if1.address = a;
    if1.memory_read = 1'b1;
    tick();
    idle_all();
    check_eq({tag, "_valid"}, 32'(if1.read_valid), 32'd1);
    check_eq(tag, if1.read_data, exp);
  endtask

  // Holds requests asserted during the sweep; none may be acted on.
  task automatic wait_ready(input string tag);
    int n, n1, n3;
    logic seen;
    n = 0; n1 = 0; n3 = 0; seen = 1'b0;
    if1.address = 32'h0; if1.write_data = '1; if1.byte_enable = '1;
    if1.memory_read = 1'b1; if1.memory_write = 1'b1;
    if3.address = 32'h4; if3.write_data = '1; if3.byte_enable = '1;
    if3.memory_read = 1'b1; if3.memory_write = 1'b1;
    while (n < 200 && (n1 == 0 || n3 == 0)) begin
      tick();
      n++;
      if (if1.ready && n1 == 0) n1 = n;
      if (if3.ready && n3 == 0) n3 = n;
      if (if1.read_valid || if1.addr_error || if3.read_valid || if3.addr_error) seen = 1'b1;
    end
    idle_all();
    check_eq({tag, "_ready_cycles_l1"}, 32'(n1), 32'd64);
    check_eq({tag, "_ready_cycles_l3"}, 32'(n3), 32'd64);
    check_eq({tag, "_init_ignored"}, 32'(seen), 32'd0);
    check_eq({tag, "_state_l1"}, 32'(st1), 32'(READY));
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    idle_all();
    rst = 1'b1;
    #12;
    check_eq("rst_ready", 32'(if1.ready), 32'd0);
    check_eq("rst_rdata", if1.read_data, 32'h0);
    check_eq("rst_rvalid", 32'(if1.read_valid), 32'd0);
    check_eq("rst_addr_err", 32'(if1.addr_error), 32'd0);
    check_eq("rst_state", 32'(st1), 32'(INIT));
    tick();
    rst = 1'b0;
    wait_ready("boot");

    rd1("rd_0x40", 32'h40, 32'h0);
    rd1("rd_0x0_after_init", 32'h0, 32'h0);

    wr(1, 32'h0,  32'h4,        4'hf);
    wr(1, 32'hc,  32'd40,       4'hf);
    wr(1, 32'hc8, 32'haaaaffff, 4'hf);
    wr(1, 32'hf0, 32'hffff0000, 4'hf);
    check_eq("wr_no_err", 32'(if1.addr_error), 32'd0);
    rd1("rd_0xf0", 32'hf0, 32'hffff0000);
    rd1("rd_0xc8", 32'hc8, 32'haaaaffff);
    rd1("rd_0xc",  32'hc,  32'd40);
    rd1("rd_0x0",  32'h0,  32'h4);

    wr(1, 32'h10, 32'hffffffff, 4'hf);
    wr(1, 32'h10, 32'h12345678, 4'b0101);
    rd1("byte_lanes", 32'h10, 32'hff34ff78);
    tick();
    check_eq("hold_rvalid", 32'(if1.read_valid), 32'd0);
    check_eq("hold_rdata", if1.read_data, 32'hff34ff78);

    // Bad read: misaligned and out of range.
    rd1("bad_rd_data", 32'h102, 32'h0);
    check_eq("bad_rd_err", 32'(if1.addr_error), 32'd1);
    tick();
    check_eq("bad_rd_err_pulse", 32'(if1.addr_error), 32'd0);

    if1.address = 32'h100; if1.write_data = 32'hdead; if1.byte_enable = 4'hf;
    if1.memory_write = 1'b1;
    tick();
    idle_all();
    check_eq("bad_wr_err", 32'(if1.addr_error), 32'd1);
    rd1("bad_wr_word0", 32'h0, 32'h4);

    wr(1, 32'h0, 32'hffff, 4'h0);
    check_eq("be0_no_err", 32'(if1.addr_error), 32'd0);
    rd1("be0_word0", 32'h0, 32'h4);

    wr(1, 32'h8, 32'd50, 4'hf);
    if1.address = 32'h8; if1.write_data = 32'd7; if1.byte_enable = 4'hf;
    if1.memory_write = 1'b1; if1.memory_read = 1'b1;
    tick();
    idle_all();
    check_eq("rw_same_valid", 32'(if1.read_valid), 32'd1);
    check_eq("rw_same_old", if1.read_data, 32'd50);
    rd1("rw_same_new", 32'h8, 32'd7);

    // Latency 3: back-to-back reads, results on cycles 3..5.
    wr(3, 32'h0, 32'd11, 4'hf);
    wr(3, 32'h4, 32'd22, 4'hf);
    wr(3, 32'h8, 32'd33, 4'hf);
    exp_q.push_back(32'd11);
    exp_q.push_back(32'd22);
    exp_q.push_back(32'd33);
    if3.address = 32'h0;
    if3.memory_read = 1'b1;
    for (int i = 1; i <= 6; i++) begin
      tick();
      if (i == 1) if3.address = 32'h4;
      else if (i == 2) if3.address = 32'h8;
      else if3.memory_read = 1'b0;
      check_eq($sformatf("l3_valid_c%0d", i), 32'(if3.read_valid), 32'((i >= 3 && i <= 5) ? 1 : 0));
      if (if3.read_valid && exp_q.size() > 0) begin
        check_eq($sformatf("l3_data_c%0d", i), if3.read_data, exp_q.pop_front());
      end
    end
    check_eq("l3_drained", 32'(exp_q.size()), 32'd0);
    idle_all();

    // Reset while a latency-3 read is in flight.
    if3.address = 32'h4;
    if3.memory_read = 1'b1;
    tick();
    idle_all();
    #2;
    rst = 1'b1;
    #1;
    check_eq("midrst_ready_l1", 32'(if1.ready), 32'd0);
    check_eq("midrst_ready_l3", 32'(if3.ready), 32'd0);
    check_eq("midrst_rvalid_l3", 32'(if3.read_valid), 32'd0);
    check_eq("midrst_rdata_l3", if3.read_data, 32'h0);
    check_eq("midrst_state_l3", 32'(st3), 32'(INIT));
    tick();
    check_eq("midrst_rvalid_hold", 32'(if3.read_valid), 32'd0);
    rst = 1'b0;
    wait_ready("rerun");
    rd1("rerun_word0", 32'h0, 32'h0);
    rd1("rerun_word8", 32'h8, 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
